multserial: RTL and testbench

Sequential 32×32 integer multiplier producing a 64-bit product over multiple clock cycles with a start/valid handshake. It serves as the multi-cycle multiply unit beside the datapath. It supports signed (two's-complement) and unsigned operands, selected per operation. One shift-add adder is reused each cycle in place of a combinational array.

---
 rtl/multserial_if.sv | 18 +
 rtl/multserial.sv | 83 ++++++++
 tb/tb_multserial.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multserial_if.sv
// multserial_if -- operand/result bundle for the serial multiplier.
//   mst   : multiply start, recognized only when high at a rising clk edge
//   msgn  : 1 = signed two's-complement operands, 0 = unsigned
//   a, b  : 32-bit multiplicand / multiplier, sampled on the accepting edge
//   prod  : 64-bit product, meaningful while prodv = 1
//   prodv : product valid
// master drives the request side; slave is the multiplier itself.
interface multserial_if;
    logic        mst;
    logic        msgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        prodv;

    modport master (output mst, msgn, a, b, input  prod, prodv);
    modport slave  (input  mst, msgn, a, b, output prod, prodv);
endinterface

// File: rtl/multserial.sv
// multserial -- sequential 32x32 -> 64 multiplier, radix-2 shift-add,
// one adder reused every cycle. Result appears 33 cycles after the
// accepting edge and is held until the next accepted start.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset (aborts any operation)
//   bus : multserial_if.slave (mst, msgn, a, b in; prod, prodv out)
module multserial (
    input  logic         clk,
    input  logic         rst,
    multserial_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] acc;      // [64:32] running partial sum, [31:0] remaining multiplier bits
    logic [31:0] mcand;
    logic        neg;
    logic [63:0] prod_r;
    logic        prodv_r;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] sum;
    logic [63:0] final_val;

    // Magnitudes for signed mode; 0x80000000 maps onto itself, which is
    // exactly the unsigned magnitude of -2^31.
    always_comb begin
        a_mag = (bus.msgn && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        b_mag = (bus.msgn && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    end

    // Upper half never exceeds 32 bits before the add, so 33 bits hold the carry.
    always_comb begin
        sum       = acc[64:32] + {1'b0, (acc[0] ? mcand : 32'd0)};
        final_val = neg ? (~acc[63:0] + 64'd1) : acc[63:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            prod_r  <= '0;
            prodv_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.mst) begin
                        mcand   <= a_mag;
                        acc     <= {33'd0, b_mag};
                        neg     <= bus.msgn & (bus.a[31] ^ bus.b[31]);
                        cnt     <= '0;
                        prodv_r <= 1'b0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // 32 shift-add iterations, then one edge for sign fix and latch.
                    if (cnt == 6'd32) begin
                        prod_r  <= final_val;
                        prodv_r <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        acc <= {1'b0, sum, acc[31:1]};
                        cnt <= cnt + 6'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.prod  = prod_r;
    assign bus.prodv = prodv_r;

endmodule

// File: tb/tb_multserial.sv
// tb_multserial -- self-checking bench for multserial: directed corners,
// control corners (ignored restart, mid-operation reset, back-to-back)
// and randomized operands against a plain-arithmetic reference.
module tb_multserial;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multserial_if bus ();

    multserial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Short mst pulse straddling the next rising edge; called just after a falling edge.
    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic sg);
        #4;
        bus.a    = a;
        bus.b    = b;
        bus.msgn = sg;
        bus.mst  = 1'b1;
        #2;
        bus.mst  = 1'b0;
        bus.a    = $urandom;
        bus.b    = $urandom;
        bus.msgn = 1'($urandom);
    endtask

    // Start an operation and wait for the result. spur > 0 fires an extra
    // start (with junk operands) that many cycles after the accept edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input int spur);
        logic [63:0] expv;
        int          n;
        expv = model(a, b, sg);
        pulse(a, b, sg);
        @(negedge clk);
        n = 0;
        chk({tag, "_prodv_clr"}, {63'd0, bus.prodv}, 64'd0);
        while (n < 40) begin
            if (spur > 0 && n == spur) pulse($urandom, $urandom, 1'($urandom));
            @(negedge clk);
            n++;
            if (bus.prodv === 1'b1) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_prod"}, bus.prod, expv);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] corner [6];
        checks   = 0;
        errors   = 0;
        corner   = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
        rst      = 1'b0;
        bus.mst  = 1'b0;
        bus.msgn = 1'b0;
        bus.a    = '0;
        bus.b    = '0;
        #1;
        chk("reset_prodv", {63'd0, bus.prodv}, 64'd0);
        chk("reset_prod", bus.prod, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed values; consecutive calls start on the first DONE edge.
        run_op("s_3fff_4000", 32'h3FFFFFFF, 32'h40000000, 1'b1, 0);
        chk("s_3fff_4000_lit", bus.prod, 64'h0FFFFFFFC0000000);
        run_op("s_3fff_sq", 32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 0);
        chk("s_3fff_sq_lit", bus.prod, 64'h0FFFFFFF80000001);
        run_op("u_1_2000", 32'h00000001, 32'h20000000, 1'b0, 0);
        chk("u_1_2000_lit", bus.prod, 64'h0000000020000000);
        run_op("s_1_2000", 32'h00000001, 32'h20000000, 1'b1, 0);
        chk("s_1_2000_lit", bus.prod, 64'h0000000020000000);
        run_op("s_m1_2", 32'hFFFFFFFF, 32'h00000002, 1'b1, 0);
        chk("s_m1_2_lit", bus.prod, 64'hFFFFFFFFFFFFFFFE);
        run_op("u_ff_2", 32'hFFFFFFFF, 32'h00000002, 1'b0, 0);
        chk("u_ff_2_lit", bus.prod, 64'h00000001FFFFFFFE);
        run_op("s_min_min", 32'h80000000, 32'h80000000, 1'b1, 0);
        chk("s_min_min_lit", bus.prod, 64'h4000000000000000);
        run_op("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        chk("s_min_m1_lit", bus.prod, 64'h0000000080000000);
        run_op("u_ff_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);

        // Result holds in DONE with no new start.
        repeat (3) @(negedge clk);
        chk("hold_prodv", {63'd0, bus.prodv}, 64'd1);
        chk("hold_prod", bus.prod, 64'hFFFFFFFE00000001);

        // Restart while busy must be ignored.
        run_op("ignore_mst", 32'h12345678, 32'h9ABCDEF0, 1'b1, 10);

        // Reset in the middle of an operation aborts it at once.
        pulse(32'hDEADBEEF, 32'h0BADF00D, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_prodv", {63'd0, bus.prodv}, 64'd0);
        chk("midrst_prod", bus.prod, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_noresult", {63'd0, bus.prodv}, 64'd0);
        run_op("after_rst", 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 0);

        // Randomized operands, some drawn from boundary values.
        for (int i = 0; i < 24; i++) begin
            ra = (($urandom % 4) == 0) ? corner[$urandom % 6] : 32'($urandom);
            rb = (($urandom % 4) == 0) ? corner[$urandom % 6] : 32'($urandom);
            rs = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rs, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
